// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and default constants for the SPI master controller.
//   spi_state_e      : sequencer states (IDLE, SETUP, SHIFT, NEXT, HOLD)
//   SPI_*_DEF        : default word width, SCLK half-period and CS guard time
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        NEXT  = 3'd3,
        HOLD  = 3'd4
    } spi_state_e;

    localparam int SPI_DATA_W_DEF   = 8;
    localparam int SPI_CLK_DIV_DEF  = 4;
    localparam int SPI_CS_SETUP_DEF = 2;

endpackage

// File: rtl/spi_clk_div.sv
// -----------------------------------------------------------------------------
// spi_clk_div
// SCLK generator. While en_i is high, a divider counts 0..CLK_DIV-1 and the
// registered SCLK toggles at each wrap. While en_i is low the divider and SCLK
// are held at 0, so every enable starts from a clean phase.
// Ports:
//   clk_i, rst_i   system clock, synchronous active-high reset
//   en_i           run the divider (high only while shifting)
//   rise_stb_o     high in the cycle whose closing edge drives SCLK 0->1
//   fall_stb_o     high in the cycle whose closing edge drives SCLK 1->0
//   sclk_o         registered SPI clock, idle low
// -----------------------------------------------------------------------------
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic rise_stb_o,
    output logic fall_stb_o,
    output logic sclk_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             sclk_q, sclk_d;
    logic             wrap;

    assign wrap = en_i && (div_q == DIV_W'(CLK_DIV - 1));

    // Strobes are combinational so the controller acts on the same edge that
    // moves SCLK; its own registers then change together with the pin.
    assign rise_stb_o = wrap && !sclk_q;
    assign fall_stb_o = wrap &&  sclk_q;
    assign sclk_o     = sclk_q;

    always_comb begin
        div_d  = div_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            div_d  = '0;
            sclk_d = 1'b0;
        end else if (wrap) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            div_d  = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
// SPI master transaction sequencer, mode 0 (CPOL=0, CPHA=0). Words arrive on a
// valid/ready stream; tx_last_i closes a frame. Chip select stays low across
// all words of a frame, with a CS_SETUP-cycle guard before the first word and
// after the last SCLK falling edge.
// Ports:
//   clk_i, rst_i          system clock, synchronous active-high reset
//   tx_valid_i/tx_ready_o upstream handshake (ready only in IDLE and NEXT)
//   tx_data_i, tx_last_i  word to send and end-of-frame flag
//   rx_valid_o, rx_data_o one-cycle pulse with the received word (held)
//   sclk_o, mosi_o, miso_i, cs_n_o  SPI pins
//   busy_o                high whenever the sequencer is not IDLE
// Optional build macro SPI_LSB_FIRST_EN: adds lsb_first_i, latched with each
// accepted word, selecting LSB-first transmit and receive bit order.
// -----------------------------------------------------------------------------
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W   = SPI_DATA_W_DEF,
    parameter int CLK_DIV  = SPI_CLK_DIV_DEF,
    parameter int CS_SETUP = SPI_CS_SETUP_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tx_valid_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_last_i,
    output logic              tx_ready_o,
    output logic              rx_valid_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              sclk_o,
    output logic              mosi_o,
    input  logic              miso_i,
`ifdef SPI_LSB_FIRST_EN
    input  logic              lsb_first_i,
`endif
    output logic              cs_n_o,
    output logic              busy_o
);

    localparam int BC_W  = $clog2(DATA_W + 1);
    localparam int CNT_W = (CS_SETUP > 1) ? $clog2(CS_SETUP) : 1;

    function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = v[DATA_W-1-i];
        end
        return r;
    endfunction

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] tx_word;

    logic accept;
    logic cnt_done;
    logic word_end;
    logic shift_en;
    logic rise_stb, fall_stb;
    logic lsb_acc;   // bit order requested with the word being accepted
    logic lsb_cur;   // bit order of the word currently on the wire

`ifdef SPI_LSB_FIRST_EN
    logic lsb_q;

    assign lsb_acc = lsb_first_i;
    assign lsb_cur = lsb_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lsb_q <= 1'b0;
        end else if (accept) begin
            lsb_q <= lsb_first_i;
        end
    end
`else
    assign lsb_acc = 1'b0;
    assign lsb_cur = 1'b0;
`endif

    assign shift_en = (state_q == SHIFT);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (shift_en),
        .rise_stb_o (rise_stb),
        .fall_stb_o (fall_stb),
        .sclk_o     (sclk_o)
    );

    assign accept   = tx_valid_i && tx_ready_o;
    assign cnt_done = (cnt_q == CNT_W'(CS_SETUP - 1));
    // The word ends on the falling edge that follows the DATA_W-th rising edge.
    assign word_end = shift_en && fall_stb && (bit_cnt_q == BC_W'(DATA_W));

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)   state_d = SETUP;
            SETUP:   if (cnt_done) state_d = SHIFT;
            SHIFT:   if (word_end) state_d = last_q ? HOLD : NEXT;
            NEXT:    if (accept)   state_d = SHIFT;
            HOLD:    if (cnt_done) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; ready is masked while reset is held.
    always_comb begin
        tx_ready_o = !rst_i && ((state_q == IDLE) || (state_q == NEXT));
        busy_o     = (state_q != IDLE);
    end

    // Datapath next-state
    always_comb begin
        cnt_d      = '0;
        bit_cnt_d  = bit_cnt_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        last_d     = last_q;
        tx_word    = lsb_acc ? bit_rev(tx_data_i) : tx_data_i;

        if (((state_q == SETUP) || (state_q == HOLD)) && !cnt_done) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // The transmit word is stored in wire order, so the shifter always
        // emits from its top bit regardless of the selected bit order.
        if (accept) begin
            cs_n_d  = 1'b0;
            mosi_d  = tx_word[DATA_W-1];
            tx_sh_d = {tx_word[DATA_W-2:0], 1'b0};
            last_d  = tx_last_i;
        end

        if (!shift_en) begin
            bit_cnt_d = '0;
        end else if (rise_stb) begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
            rx_sh_d   = {rx_sh_q[DATA_W-2:0], miso_i};
        end

        if (word_end) begin
            rx_valid_d = 1'b1;
            rx_data_d  = lsb_cur ? bit_rev(rx_sh_q) : rx_sh_q;
        end else if (shift_en && fall_stb) begin
            mosi_d  = tx_sh_q[DATA_W-1];
            tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
        end

        if ((state_q == HOLD) && cnt_done) begin
            cs_n_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            last_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            last_q     <= last_d;
        end
    end

    assign rx_valid_o = rx_valid_q;
    assign rx_data_o  = rx_data_q;
    assign mosi_o     = mosi_q;
    assign cs_n_o     = cs_n_q;

endmodule
